// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg
//   Shared types and helpers for the tick_timer block.
//   - ch_mode_t  : channel countdown mode latched on load.
//   - ch_state_t : per-channel state machine encoding.
//   - tick_div / tick_div_ok : prescaler divide ratio and its legality check.
package tick_timer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } ch_mode_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  // Clocks per tick.
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

  // The divide ratio must be an exact integer of at least 2.
  function automatic bit tick_div_ok(input int unsigned clk_hz,
                                     input int unsigned tick_hz);
    return (tick_hz != 0) && ((clk_hz % tick_hz) == 0) && ((clk_hz / tick_hz) >= 2);
  endfunction

endpackage

// File: rtl/tick_timer_channel.sv
// tick_timer_channel
//   One countdown channel: IDLE/RUN state machine plus latched period, mode
//   and remaining-tick counter. Per-cycle priority is load > stop > tick.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tick              qualified tick strobe (already gated by any pause)
//   load              load/restart strobe; period 0 acts as stop
//   mode              sampled on load: 0 one-shot, 1 periodic
//   period [WIDTH]    period in ticks, sampled on load
//   stop              stop strobe
//   busy              channel is in RUN
//   expire            registered one-cycle expiry strobe
module tick_timer_channel
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic             stop,
  output logic             busy,
  output logic             expire
);

  ch_state_t        state, state_nxt;
  ch_mode_t         mode_q, mode_nxt;
  logic [WIDTH-1:0] period_q, period_nxt;
  logic [WIDTH-1:0] remain_q, remain_nxt;
  logic             expire_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      mode_q   <= MODE_ONESHOT;
      period_q <= '0;
      remain_q <= '0;
      expire   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      period_q <= period_nxt;
      remain_q <= remain_nxt;
      expire   <= expire_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    period_nxt = period_q;
    remain_nxt = remain_q;
    expire_nxt = 1'b0;

    if (load) begin
      // A load wins over a coinciding tick, so the new period starts
      // counting from the next tick and any pending expire is dropped.
      if (period != '0) begin
        state_nxt  = CH_RUN;
        mode_nxt   = ch_mode_t'(mode);
        period_nxt = period;
        remain_nxt = period;
      end else begin
        state_nxt  = CH_IDLE;
        remain_nxt = '0;
      end
    end else if (stop) begin
      if (state == CH_RUN) begin
        state_nxt  = CH_IDLE;
        remain_nxt = '0;
      end
    end else if (tick && (state == CH_RUN)) begin
      if (remain_q > WIDTH'(1)) begin
        remain_nxt = remain_q - WIDTH'(1);
      end else begin
        expire_nxt = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          remain_nxt = period_q;
        end else begin
          state_nxt  = CH_IDLE;
          remain_nxt = '0;
        end
      end
    end
  end

  assign busy = (state == CH_RUN);

endmodule

// File: rtl/tick_timer.sv
// tick_timer
//   Multi-channel tick timer. A prescaler divides clk by DIV = CLK_HZ/TICK_HZ
//   to make a one-cycle tick strobe; out_time counts ticks and wraps silently.
//   CHANNELS independent countdown channels (one-shot or periodic) run off
//   the tick.
//   Optional feature macro: TICK_TIMER_PAUSE_EN adds a pause input that
//   freezes the prescaler, out_time and all channels (load/stop still act).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   tick                       one-cycle strobe every DIV clocks
//   out_time [WIDTH]           free-running tick count
//   ch_load/ch_mode/ch_stop    per-channel load strobe, mode, stop strobe
//   ch_period [CHANNELS*WIDTH] channel i period at [i*WIDTH +: WIDTH]
//   ch_busy/ch_expire          per-channel RUN flag and expiry strobe
//   pause                      (TICK_TIMER_PAUSE_EN only) freeze counting
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ  = 1_000,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      tick,
  output logic [WIDTH-1:0]          out_time,
  input  logic [CHANNELS-1:0]       ch_load,
  input  logic [CHANNELS-1:0]       ch_mode,
  input  logic [CHANNELS*WIDTH-1:0] ch_period,
  input  logic [CHANNELS-1:0]       ch_stop,
  output logic [CHANNELS-1:0]       ch_busy,
  output logic [CHANNELS-1:0]       ch_expire
`ifdef TICK_TIMER_PAUSE_EN
  ,
  input  logic                      pause
`endif
);

  localparam int unsigned DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  if (!tick_div_ok(CLK_HZ, TICK_HZ) || (CHANNELS < 1)) begin : g_bad_cfg
    $error("tick_timer: CLK_HZ/TICK_HZ must be an exact integer >= 2 and CHANNELS >= 1");
  end

  logic          hold;
  logic [PW-1:0] presc;
  logic          tick_q;
  logic          tick_cnt;

`ifdef TICK_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // While held, a tick already registered is kept (but masked at the
  // output) so it is delivered on resume rather than lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      tick_q   <= 1'b0;
      out_time <= '0;
    end else if (!hold) begin
      presc  <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      tick_q <= (presc == PRESC_LAST);
      if (tick_q) begin
        out_time <= out_time + WIDTH'(1);
      end
    end
  end

  assign tick_cnt = tick_q & ~hold;
  assign tick     = tick_cnt;

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    tick_timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick_cnt),
      .load   (ch_load[i]),
      .mode   (ch_mode[i]),
      .period (ch_period[i*WIDTH +: WIDTH]),
      .stop   (ch_stop[i]),
      .busy   (ch_busy[i]),
      .expire (ch_expire[i])
    );
  end

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  localparam int unsigned CLK_HZ   = 100;
  localparam int unsigned TICK_HZ  = 10;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DIV      = CLK_HZ / TICK_HZ;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      tick;
  logic [WIDTH-1:0]          out_time;
  logic [CHANNELS-1:0]       ch_load;
  logic [CHANNELS-1:0]       ch_mode;
  logic [CHANNELS*WIDTH-1:0] ch_period;
  logic [CHANNELS-1:0]       ch_stop;
  logic [CHANNELS-1:0]       ch_busy;
  logic [CHANNELS-1:0]       ch_expire;
  logic                      pause;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ecnt;   // unpaused clock edges since reset release
  int unsigned rcnt;   // all clock edges since reset release
  int unsigned exp_q[CHANNELS][$];

  tick_timer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .out_time (out_time),
    .ch_load  (ch_load),
    .ch_mode  (ch_mode),
    .ch_period(ch_period),
    .ch_stop  (ch_stop),
    .ch_busy  (ch_busy),
    .ch_expire(ch_expire)
`ifdef TICK_TIMER_PAUSE_EN
    ,
    .pause    (pause)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt <= 0;
      rcnt <= 0;
    end else begin
      rcnt <= rcnt + 1;
      if (!pause) ecnt <= ecnt + 1;
    end
  end

  // Edge index of the P-th tick consumed strictly after the load edge L.
  function automatic int unsigned first_expire(input int unsigned l, input int unsigned p);
    int unsigned j;
    j = l + 1;
    while ((j % DIV) != 1) j++;
    return j + (p - 1) * DIV;
  endfunction

  // Reference model: tick after every DIV-th unpaused edge, out_time counts
  // ticks consumed, expiries come from the scoreboard queues.
  always @(posedge clk) begin
    logic        e;
    int unsigned t_exp;
    #1;
    if (rst) begin
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_time", 32'(out_time), 32'd0);
      check("rst_busy", 32'(ch_busy), 32'd0);
      check("rst_expire", 32'(ch_expire), 32'd0);
    end else begin
      t_exp = (ecnt == 0) ? 0 : ((ecnt - 1) / DIV) % (1 << WIDTH);
      check("tick", 32'(tick), 32'(!pause && ecnt != 0 && (ecnt % DIV) == 0));
      check("out_time", 32'(out_time), t_exp);
      for (int i = 0; i < int'(CHANNELS); i++) begin
        e = (exp_q[i].size() != 0) && (exp_q[i][0] == ecnt);
        check($sformatf("ch%0d_expire@%0d", i, ecnt), 32'(ch_expire[i]), 32'(e));
        while (exp_q[i].size() != 0 && exp_q[i][0] <= ecnt) void'(exp_q[i].pop_front());
      end
    end
  end

  // Called at a negedge; load is sampled on the next edge.
  task automatic load_ch(input int ch, input logic md, input logic [WIDTH-1:0] per,
                         input int npush, output int unsigned j_first);
    int unsigned l;
    l = ecnt + 1;
    j_first = (per != 0) ? first_expire(l, 32'(per)) : 0;
    for (int m = 0; m < npush; m++) exp_q[ch].push_back(j_first + m * 32'(per) * DIV);
    ch_load[ch] = 1'b1;
    ch_mode[ch] = md;
    ch_period[ch*WIDTH +: WIDTH] = per;
    @(negedge clk);
    ch_load[ch] = 1'b0;
  endtask

  task automatic stop_ch(input int ch);
    ch_stop[ch] = 1'b1;
    @(negedge clk);
    ch_stop[ch] = 1'b0;
  endtask

  task automatic wait_until(input int unsigned t);
    while (ecnt < t) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned j0, j1, j2, jb, r0;
    rst = 1'b1; pause = 1'b0;
    ch_load = '0; ch_mode = '0; ch_stop = '0; ch_period = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Free-running count
    wait_until(1001);
    check("time_1000clk", 32'(out_time), 32'd100);

    // Mid-count asynchronous reset aborts a running channel with no expire
    load_ch(2, 1'b1, 8'd4, 0, j0);
    repeat (15) @(negedge clk);
    check("ch2_busy_pre_rst", 32'(ch_busy[2]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_time", 32'(out_time), 32'd0);
    check("midrst_tick", 32'(tick), 32'd0);
    check("midrst_busy", 32'(ch_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // out_time wrap
    wait_until(2560);
    check("wrap_pre", 32'(out_time), 32'd255);
    @(negedge clk);
    check("wrap_post", 32'(out_time), 32'd0);
    wait_until(25601);
    check("wrap_2560ticks", 32'(out_time), 32'd0);

    // ch0 one-shot, period 3
    load_ch(0, 1'b0, 8'd3, 1, j0);
    check("ch0_busy_rise", 32'(ch_busy[0]), 32'd1);
    wait_until(j0 - 1);
    check("ch0_busy_before", 32'(ch_busy[0]), 32'd1);
    @(negedge clk);
    check("ch0_busy_after", 32'(ch_busy[0]), 32'd0);

    // ch1 periodic period 2 (5 periods), ch2 periodic stopped after one
    // expire, ch3 loaded with period 0
    load_ch(1, 1'b1, 8'd2, 5, j1);
    load_ch(2, 1'b1, 8'd3, 1, j2);
    load_ch(3, 1'b0, 8'd0, 0, jb);
    check("ch3_busy_zero_load", 32'(ch_busy[3]), 32'd0);
    wait_until(j2);
    stop_ch(2);
    check("ch2_busy_after_stop", 32'(ch_busy[2]), 32'd0);
    wait_until(j1 + 4 * 2 * DIV);
    stop_ch(1);
    check("ch1_busy_after_stop", 32'(ch_busy[1]), 32'd0);
    check("ch3_busy_late", 32'(ch_busy[3]), 32'd0);
    repeat (80) @(negedge clk);

    // Load coinciding with tick: that tick is not counted
    while ((ecnt % DIV) != 0) @(negedge clk);
    load_ch(0, 1'b0, 8'd2, 1, j0);
    // Reload ch1 on its expire edge: expire suppressed, count restarts
    load_ch(1, 1'b1, 8'd3, 0, j1);
    wait_until(j1 - 1);
    load_ch(1, 1'b1, 8'd2, 2, jb);
    check("ch1_busy_reload", 32'(ch_busy[1]), 32'd1);
    wait_until(jb + 2 * DIV);
    stop_ch(1);

`ifdef TICK_TIMER_PAUSE_EN
    // Pause for 35 clocks mid-count
    load_ch(0, 1'b1, 8'd3, 2, j0);
    while ((ecnt % DIV) != 5) @(negedge clk);
    r0 = rcnt;
    pause = 1'b1;
    repeat (35) @(negedge clk);
    check("pause_busy", 32'(ch_busy[0]), 32'd1);
    pause = 1'b0;
    for (int k = 0; k < 20 && !tick; k++) @(negedge clk);
    check("pause_tick_late", rcnt, r0 + 40);
    wait_until(j0 + 3 * DIV);
    stop_ch(0);
`else
    r0 = 0;
`endif

    repeat (60) @(negedge clk);
    for (int i = 0; i < int'(CHANNELS); i++)
      check($sformatf("ch%0d_missing", i), 32'(exp_q[i].size()), 32'd0);
    check("final_busy", 32'(ch_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
# tick_timer

Parametrised multi-channel tick timer for the MIDI synth datapath. A clock prescaler produces a one-cycle `tick` strobe at a configured rate, and a free-running `out_time` counter counts ticks. It also provides CHANNELS independent countdown channels, each one-shot or periodic, for note-length, envelope and sequencer event timing. It generalises the single 16-bit free-running timer: it adds configurable width, configurable tick rate, per-channel countdowns with expiry strobes, and an optional pause.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 1_000, tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be ≥ 2 and an exact integer; elaboration error otherwise.
- WIDTH, 16, width of `out_time` and of each channel period/remaining count.
- CHANNELS, 4, number of countdown channels, ≥ 1.

- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- tick  out  1  one-cycle strobe every DIV clocks.
- out_time  out  WIDTH  free-running tick count.
- ch_load  in  CHANNELS  per-channel load/restart strobe.
- ch_mode  in  CHANNELS  sampled on load: 0 = one-shot, 1 = periodic.
- ch_period  in  CHANNELS*WIDTH  period in ticks; channel i uses bits [i*WIDTH +: WIDTH]; sampled on load.
- ch_stop  in  CHANNELS  per-channel stop strobe.
- ch_busy  out  CHANNELS  channel in RUN.
- ch_expire  out  CHANNELS  one-cycle expiry strobe.
- pause  in  1  present only with TICK_TIMER_PAUSE_EN.

## Operation
- Prescaler counts 0..DIV-1 and wraps. `tick` is registered and is high in the cycle after the count reaches DIV-1.
- `out_time` increments by 1 in the cycle where `tick` is high. It wraps from 2^WIDTH-1 to 0 with no flag.
- Each channel has state IDLE or RUN, plus registered `period`, `remaining` and `mode`.
- Load with a nonzero period, in any state:
  - period and mode are latched;
  - remaining is set to period;
  - the channel goes to RUN.
- Load with period 0: the channel goes to IDLE and no expire is produced, i.e. it behaves as stop.
- Stop: the channel goes to IDLE and remaining is cleared. Stop in IDLE has no effect.
- RUN on tick with remaining > 1: remaining is decremented.
- RUN on tick with remaining == 1: `ch_expire` is asserted.
  - One-shot: the channel goes to IDLE.
  - Periodic: remaining is reloaded from the latched period and the channel stays in RUN.
- Priority per channel and per cycle: load > stop > tick.
  - A tick coinciding with a load is not counted against the new period.
- Channels are fully independent. Several channels may expire in the same cycle.
- Reset values: prescaler 0, `tick` 0, `out_time` 0, all channels IDLE, `ch_busy` 0, `ch_expire` 0, period/remaining/mode 0.
- Reset mid-operation aborts all countdowns immediately, with no expire.

## Timing
- `tick` period is exactly DIV clocks. The first `tick` comes DIV clocks after reset deasserts.
- `ch_busy` rises the cycle after load and falls the cycle after stop or one-shot expiry.
- `ch_expire` is registered. It is high in the cycle after the tick on which remaining was 1, i.e. period×DIV (+1) clocks after the load edge, measured to the first tick following load.
- In periodic mode, `ch_expire` recurs exactly every period×DIV clocks.
- A load in the same cycle as a pending expire edge restarts the channel and suppresses that expire.

## Configuration
- TICK_TIMER_PAUSE_EN defined:
  - `pause` port exists;
  - while `pause` is high, the prescaler holds its count, `tick` stays 0, and `out_time` and all channels freeze;
  - load and stop still act;
  - counting resumes from the held prescaler value.
- Macro undefined: no `pause` port, and counting is never frozen.

## Structure
- `tick_timer_pkg`:
  - `ch_mode_t` enum (MODE_ONESHOT, MODE_PERIODIC);
  - `ch_state_t` enum (CH_IDLE, CH_RUN);
  - DIV computation function.
- Sub-module `tick_timer_channel` holds one channel's state machine and counter, parametrised by WIDTH.
- Top level holds the prescaler and `out_time`, and instantiates the channel CHANNELS times via generate.

## Test plan
CLK_HZ=100, TICK_HZ=10 (DIV=10), WIDTH=8, CHANNELS=4.
- Reset, then run 1000 clocks. Require:
  - `tick` every 10 clocks;
  - `out_time` = 100;
  - during reset all outputs are 0 and `rst` asserted mid-count clears immediately.
- Run 2560 ticks. Require `out_time` wraps 255→0 with no glitch on `tick`.
- ch0 one-shot, period 3. Require a single `ch_expire[0]` after the third tick, then `ch_busy[0]`=0.
- ch1 periodic, period 2. Require `ch_expire[1]` every 20 clocks across 5 periods.
- ch2 periodic, stop after 1 expire. Require no further expires.
- ch3 load with period 0. Require `ch_busy[3]`=0 and no expire.
- Load ch0 in the same cycle as `tick`, and load ch1 at the expire edge. Require the tick is not counted, and the expire is suppressed and restarted.
- With TICK_TIMER_PAUSE_EN, hold `pause` for 35 clocks mid-count. Require `out_time` and remaining are unchanged and the next `tick` lands 35 clocks late.
